// File: rtl/deco_pkg.sv
// Shared types for the decompressor prefetch queue: FIFO entry and in-flight tag layouts.
package deco_pkg;

    localparam int DECO_DATA_W = 32;
    localparam int DECO_ADDR_W = 32;
    localparam logic [DECO_DATA_W-1:0] DECO_HALT_INSTR = 32'h1EFF2FE1;

    typedef struct packed {
        logic [DECO_ADDR_W-1:0] pc;
        logic [DECO_DATA_W-1:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic                   valid;
        logic [DECO_ADDR_W-1:0] pc;
    } inflight_tag_t;

endpackage

// File: rtl/deco_fetch_fifo.sv
// Show-ahead FIFO of fetch entries with synchronous flush and occupancy count.
module deco_fetch_fifo
    import deco_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             wdata_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output fetch_entry_t             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/deco_prefetch_queue.sv
// Prefetch queue: issues sequential PCs to the decompressor, tracks them in flight, buffers results.
// Optional halt-instruction detection is enabled by defining DECO_HALT_DETECT_EN.
module deco_prefetch_queue
    import deco_pkg::*;
#(
    parameter int                DATA_W   = DECO_DATA_W,
    parameter int                ADDR_W   = DECO_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DECO_LAT = 1
`ifdef DECO_HALT_DETECT_EN
    ,
    parameter logic [DATA_W-1:0] HALT_INSTR = DECO_HALT_INSTR
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_W-1:0]      deco_pc,
    input  logic [DATA_W-1:0]      deco_instr,
    output logic                   cpu_valid,
    input  logic                   cpu_ready,
    output logic [DATA_W-1:0]      cpu_instr,
    output logic [ADDR_W-1:0]      cpu_pc,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic [$clog2(DEPTH):0] count
`ifdef DECO_HALT_DETECT_EN
    ,
    output logic                   halted
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    inflight_tag_t     tag_q [DECO_LAT];
    inflight_tag_t     tag_d [DECO_LAT];
    logic [ADDR_W-1:0] deco_pc_q;
    logic [ADDR_W-1:0] deco_pc_d;
    logic [CW:0]       inflight;
    logic [CW-1:0]     fifo_count;
    logic              capture;
    logic              halt_hit;
    logic              halted_q;
    logic              issue;
    logic              credit_ok;
    logic              push;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < DECO_LAT; i++) inflight = inflight + (CW+1)'(tag_q[i].valid);
    end

    // Credit counts both buffered and in-flight words so a capture always finds a free slot.
    assign credit_ok = ({1'b0, fifo_count} + inflight) < (CW+1)'(DEPTH);
    assign capture   = tag_q[DECO_LAT-1].valid;
    assign issue     = !redirect && !halted_q && !halt_hit && credit_ok;
    assign push      = capture && !redirect;

`ifdef DECO_HALT_DETECT_EN
    logic halted_d;
    assign halt_hit = capture && (deco_instr == HALT_INSTR);
    assign halted_d = redirect ? 1'b0 : (halt_hit ? 1'b1 : halted_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end

    assign halted = halted_q;
`else
    assign halt_hit = 1'b0;
    assign halted_q = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < DECO_LAT; i++) tag_d[i] = '0;
        tag_d[0].valid = issue;
        tag_d[0].pc    = deco_pc_q;
        for (int i = 1; i < DECO_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
            if (redirect || halt_hit) tag_d[i].valid = 1'b0;
        end
    end

    assign deco_pc_d = redirect ? redirect_pc
                     : (issue ? deco_pc_q + ADDR_W'(PC_STEP) : deco_pc_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deco_pc_q <= RESET_PC;
            for (int i = 0; i < DECO_LAT; i++) tag_q[i] <= '0;
        end else begin
            deco_pc_q <= deco_pc_d;
            for (int i = 0; i < DECO_LAT; i++) tag_q[i] <= tag_d[i];
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = tag_q[DECO_LAT-1].pc;
        push_entry.instr = deco_instr;
    end

    deco_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .flush_i (redirect),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (cpu_ready),
        .valid_o (cpu_valid),
        .rdata_o (head_entry),
        .count_o (fifo_count)
    );

    assign deco_pc   = deco_pc_q;
    assign cpu_pc    = head_entry.pc;
    assign cpu_instr = head_entry.instr;
    assign count     = fifo_count;

endmodule

// File: tb/tb_deco_prefetch_queue.sv
// Directed bench for deco_prefetch_queue with a delivered-PC scoreboard.
module tb_deco_prefetch_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   deco_pc;
    logic [31:0]   deco_instr = '0;
    logic          cpu_valid;
    logic          cpu_ready = 1'b0;
    logic [31:0]   cpu_instr;
    logic [31:0]   cpu_pc;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic [CW-1:0] count;
`ifdef DECO_HALT_DETECT_EN
    logic          halted;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    deco_prefetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .deco_pc     (deco_pc),
        .deco_instr  (deco_instr),
        .cpu_valid   (cpu_valid),
        .cpu_ready   (cpu_ready),
        .cpu_instr   (cpu_instr),
        .cpu_pc      (cpu_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .count       (count)
`ifdef DECO_HALT_DETECT_EN
        ,
        .halted      (halted)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_instr(input logic [31:0] pc);
`ifdef DECO_HALT_DETECT_EN
        if (pc == 32'h1BC) return 32'h1EFF2FE1;
`endif
        return pc ^ 32'hA5A50000;
    endfunction

    // One-cycle decompressor model
    always @(posedge clk) deco_instr <= model_instr(deco_pc);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scores any handshake about to complete, then advances to the next falling edge.
    task automatic cycle();
        logic [31:0] e;
        if (cpu_valid && cpu_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_delivery observed=%h expected=none", cpu_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("cpu_pc", 64'(cpu_pc), 64'(e));
                chk("cpu_instr", 64'(cpu_instr), 64'(model_instr(e)));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input logic [31:0] start, input int n);
        int guard;
        guard = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i * 4));
        cpu_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 60) begin
            cycle();
            guard++;
        end
        cpu_ready = 1'b0;
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        logic [31:0] held_pc;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_deco_pc", 64'(deco_pc), 64'h0);
        chk("rst_valid", 64'(cpu_valid), 64'd0);
        chk("rst_instr", 64'(cpu_instr), 64'h0);
        chk("rst_pc", 64'(cpu_pc), 64'h0);
        chk("rst_count", 64'(count), 64'd0);
`ifdef DECO_HALT_DETECT_EN
        chk("rst_halted", 64'(halted), 64'd0);
`endif

        // Streaming with cpu_ready held high
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        reset = 1'b1;
        cpu_ready = 1'b1;
        cycle();
        chk("e1_valid", 64'(cpu_valid), 64'd0);
        chk("e1_deco_pc", 64'(deco_pc), 64'h4);
        cycle();
        chk("e2_valid", 64'(cpu_valid), 64'd1);
        chk("e2_deco_pc", 64'(deco_pc), 64'h8);
        chk("e2_count", 64'(count), 64'd1);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        cpu_ready = 1'b0;
        chk("stream_cycles", 64'(n), 64'd8);

        // Asynchronous reset mid-operation
        #2 reset = 1'b0;
        #1;
        chk("arst_deco_pc", 64'(deco_pc), 64'h0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(cpu_valid), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;

        // Back-pressure: queue fills and fetch stalls
        repeat (10) cycle();
        chk("bp_count", 64'(count), 64'd4);
        chk("bp_deco_pc", 64'(deco_pc), 64'h10);
        drain(32'h0, 5);
        repeat (6) cycle();
        chk("refill_count", 64'(count), 64'd4);

        // Redirect while full
        redirect = 1'b1;
        redirect_pc = 32'h1B0;
        cycle();
        redirect = 1'b0;
        chk("rd_count", 64'(count), 64'd0);
        chk("rd_valid", 64'(cpu_valid), 64'd0);
        chk("rd_deco_pc", 64'(deco_pc), 64'h1B0);
        cycle();
        chk("rd1_valid", 64'(cpu_valid), 64'd0);
        cycle();
        chk("rd2_valid", 64'(cpu_valid), 64'd1);
        chk("rd2_pc", 64'(cpu_pc), 64'h1B0);
        drain(32'h1B0, 4);
`ifdef DECO_HALT_DETECT_EN
        cpu_ready = 1'b1;
        repeat (6) cycle();
        cpu_ready = 1'b0;
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_count", 64'(count), 64'd0);
        chk("halt_deco_pc", 64'(deco_pc), 64'h1C0);
        held_pc = deco_pc;
        repeat (3) cycle();
        chk("halt_frozen", 64'(deco_pc), 64'(held_pc));
`endif

        // Redirect on the same edge as a capture and a pop
        redirect = 1'b1;
        redirect_pc = 32'h200;
        cycle();
        redirect = 1'b0;
`ifdef DECO_HALT_DETECT_EN
        chk("halt_cleared", 64'(halted), 64'd0);
`endif
        cpu_ready = 1'b1;
        cycle();
        chk("cp_pre_valid", 64'(cpu_valid), 64'd0);
        cycle();
        chk("cp_head", 64'(cpu_pc), 64'h200);
        exp_q.push_back(32'h200);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        cycle();
        redirect = 1'b0;
        cpu_ready = 1'b0;
        chk("cp_count", 64'(count), 64'd0);
        chk("cp_valid", 64'(cpu_valid), 64'd0);
        chk("cp_consumed", 64'(exp_q.size()), 64'd0);
        drain(32'h300, 2);

        // PC wrap-around
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        drain(32'hFFFF_FFF8, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
